clock_time_ctrl: RTL and testbench

Timekeeping and time-set controller for the digital clock. It consumes the 1 Hz tick pulse and the blink square wave from the tick generator. It maintains hours, minutes and seconds, and sequences a button-driven set mode (hours, then minutes, then seconds). It also drives per-field blank flags so the display flashes the field being edited. It sits between the tick generator / button debouncers and the display decoder.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/wrap_counter.sv | 32 +++
 rtl/clock_time_ctrl.sv | 124 ++++++++++++
 tb/tb_clock_time_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock timekeeping path: state
// encoding of the set-mode FSM, field widths and field limits.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } mode_e;

    localparam int HH_W   = 5;
    localparam int MS_W   = 6;
    localparam int HH_MAX = 23;
    localparam int MS_MAX = 59;

    // btn_mode walks RUN -> SET_HH -> SET_MM -> SET_SS -> RUN
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            RUN:     nxt = SET_HH;
            SET_HH:  nxt = SET_MM;
            SET_MM:  nxt = SET_SS;
            default: nxt = RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) counter used for each time field. The wrap output is the
// combinational carry-out (inc while at MAX) so the next field can advance
// on the same edge.
module wrap_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // carry-out toward the next more significant field
    assign wrap = inc && (value == MAX_V);

    // count up, returning to zero after MAX so the value stays in range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller. Keeps hh:mm:ss from the 1 Hz tick,
// runs the button-driven set mode and produces the per-field blink blanking.
// Optional macro CLOCK_SET_TIMEOUT_EN: a SET state idle for TIMEOUT_S ticks
// falls back to RUN keeping the edited time.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_1hz,
    input  logic            blink_2hz,
    input  logic            btn_mode,
    input  logic            btn_inc,
    output logic [HH_W-1:0] hh,
    output logic [MS_W-1:0] mm,
    output logic [MS_W-1:0] ss,
    output logic [1:0]      set_mode,
    output logic            blank_hh,
    output logic            blank_mm,
    output logic            blank_ss,
    output logic            day_pulse
);

    mode_e state_reg;
    logic  blank_hh_reg;
    logic  blank_mm_reg;
    logic  blank_ss_reg;
    logic  day_pulse_reg;

    logic  run;
    logic  edit_ok;
    logic  hh_inc, mm_inc, ss_inc;
    logic  hh_wrap, mm_wrap, ss_wrap;

    assign run     = (state_reg == RUN);
    // btn_mode takes priority, so a coincident increment is discarded
    assign edit_ok = btn_inc && !btn_mode;

    // RUN chains carries through all fields; SET edits one field, no carry
    assign ss_inc = run ? tick_1hz : ((state_reg == SET_SS) && edit_ok);
    assign mm_inc = run ? ss_wrap  : ((state_reg == SET_MM) && edit_ok);
    assign hh_inc = run ? mm_wrap  : ((state_reg == SET_HH) && edit_ok);

    wrap_counter #(.W(MS_W), .MAX(MS_MAX)) u_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ss_inc),
        .clear (1'b0),
        .value (ss),
        .wrap  (ss_wrap)
    );

    wrap_counter #(.W(MS_W), .MAX(MS_MAX)) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mm_inc),
        .clear (1'b0),
        .value (mm),
        .wrap  (mm_wrap)
    );

    wrap_counter #(.W(HH_W), .MAX(HH_MAX)) u_hh (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hh_inc),
        .clear (1'b0),
        .value (hh),
        .wrap  (hh_wrap)
    );

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int                 TO_W    = $clog2(TIMEOUT_S + 1);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_S - 1);
    logic [TO_W-1:0] to_cnt_reg;
`else
    // parameter kept for a uniform interface; no timeout logic in this build
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_S != 0);
`endif

    // set-mode FSM with registered blanking, rollover pulse and idle timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            blank_hh_reg  <= 1'b0;
            blank_mm_reg  <= 1'b0;
            blank_ss_reg  <= 1'b0;
            day_pulse_reg <= 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
            to_cnt_reg    <= '0;
`endif
        end else begin
            blank_hh_reg  <= (state_reg == SET_HH) && blink_2hz;
            blank_mm_reg  <= (state_reg == SET_MM) && blink_2hz;
            blank_ss_reg  <= (state_reg == SET_SS) && blink_2hz;
            // an hours carry in RUN only happens at 23:59:59 -> 00:00:00
            day_pulse_reg <= run && hh_wrap;
            if (btn_mode) begin
                state_reg <= next_mode(state_reg);
            end
`ifdef CLOCK_SET_TIMEOUT_EN
            if (run || btn_mode || btn_inc) begin
                to_cnt_reg <= '0;
            end else if (tick_1hz) begin
                if (to_cnt_reg == TO_LAST) begin
                    to_cnt_reg <= '0;
                    state_reg  <= RUN;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end
`endif
        end
    end

    assign set_mode  = state_reg;
    assign blank_hh  = blank_hh_reg;
    assign blank_mm  = blank_mm_reg;
    assign blank_ss  = blank_ss_reg;
    assign day_pulse = day_pulse_reg;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl. Time is modelled as seconds of
// the day; set mode, blanking and rollover are derived from that.
module tb_clock_time_ctrl;

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int TO_S = 3;
`else
    localparam int TO_S = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       blink_2hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [1:0] set_mode;
    logic       blank_hh, blank_mm, blank_ss, day_pulse;

    clock_time_ctrl #(.TIMEOUT_S(TO_S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .blink_2hz (blink_2hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .set_mode  (set_mode),
        .blank_hh  (blank_hh),
        .blank_mm  (blank_mm),
        .blank_ss  (blank_ss),
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    int t_sec  = 0;   // seconds since midnight
    int md     = 0;   // 0 run, 1 hours, 2 minutes, 3 seconds
    int to_cnt = 0;
    bit exp_day = 0, exp_bh = 0, exp_bm = 0, exp_bs = 0;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic compare_all();
        check_val("hh", int'(hh), t_sec / 3600);
        check_val("mm", int'(mm), (t_sec / 60) % 60);
        check_val("ss", int'(ss), t_sec % 60);
        check_val("set_mode", int'(set_mode), md);
        check_val("blank_hh", int'(blank_hh), int'(exp_bh));
        check_val("blank_mm", int'(blank_mm), int'(exp_bm));
        check_val("blank_ss", int'(blank_ss), int'(exp_bs));
        check_val("day_pulse", int'(day_pulse), int'(exp_day));
    endtask

    task automatic model_reset();
        t_sec = 0; md = 0; to_cnt = 0;
        exp_day = 0; exp_bh = 0; exp_bm = 0; exp_bs = 0;
    endtask

    task automatic model_step(input bit tk, input bit bm, input bit bi, input bit bl);
        int h, m, s;
        int pm;
        pm = md;
        exp_bh  = (pm == 1) && bl;
        exp_bm  = (pm == 2) && bl;
        exp_bs  = (pm == 3) && bl;
        exp_day = 0;
        if (pm == 0) begin
            if (tk) begin
                if (t_sec == 86399) exp_day = 1;
                t_sec = (t_sec + 1) % 86400;
            end
            if (bm) md = 1;
            to_cnt = 0;
        end else if (bm) begin
            md = (pm + 1) % 4;
            to_cnt = 0;
        end else if (bi) begin
            h = t_sec / 3600;
            m = (t_sec / 60) % 60;
            s = t_sec % 60;
            if (pm == 1) h = (h + 1) % 24;
            else if (pm == 2) m = (m + 1) % 60;
            else s = (s + 1) % 60;
            t_sec = h * 3600 + m * 60 + s;
            to_cnt = 0;
        end else if (tk) begin
`ifdef CLOCK_SET_TIMEOUT_EN
            to_cnt++;
            if (to_cnt == TO_S) begin
                md = 0;
                to_cnt = 0;
            end
`endif
        end
    endtask

    // one clock transaction: present inputs, take the edge, compare
    task automatic drive(input bit tk, input bit bm, input bit bi);
        tick_1hz = tk; btn_mode = bm; btn_inc = bi;
        @(posedge clk);
        model_step(tk, bm, bi, blink_2hz);
        cyc++;
        #1;
        tick_1hz = 0; btn_mode = 0; btn_inc = 0;
        compare_all();
        $display("cyc %0d tk=%0d bm=%0d bi=%0d bl=%0d -> %02d:%02d:%02d mode=%0d blank=%0d%0d%0d day=%0d",
                 cyc, tk, bm, bi, blink_2hz, hh, mm, ss, set_mode, blank_hh, blank_mm, blank_ss, day_pulse);
    endtask

    // asynchronous reset pulse starting mid-cycle
    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        $display("cyc %0d async reset -> %02d:%02d:%02d mode=%0d", cyc, hh, mm, ss, set_mode);
        @(posedge clk);
        cyc++;
        #1;
        compare_all();
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1;

        // 1: 61 ticks from reset
        for (int i = 0; i < 61; i++) begin
            drive(1, 0, 0);
            drive(0, 0, 0);
        end
        check_val("t1_hh", int'(hh), 0);
        check_val("t1_mm", int'(mm), 1);
        check_val("t1_ss", int'(ss), 1);

        // 2: set 23:59:58, back to RUN, roll over midnight
        drive(0, 1, 0);
        repeat (23) drive(0, 0, 1);
        drive(0, 1, 0);
        repeat (58) drive(0, 0, 1);
        drive(0, 1, 0);
        repeat (57) drive(0, 0, 1);
        check_val("t2_hh", int'(hh), 23);
        check_val("t2_mm", int'(mm), 59);
        check_val("t2_ss", int'(ss), 58);
        drive(0, 1, 0);
        check_val("t2_run", int'(set_mode), 0);
        drive(1, 0, 0);
        check_val("t2_ss59", int'(ss), 59);
        check_val("t2_noday", int'(day_pulse), 0);
        drive(1, 0, 0);
        check_val("t2_mid_hh", int'(hh), 0);
        check_val("t2_mid_ss", int'(ss), 0);
        check_val("t2_day", int'(day_pulse), 1);
        drive(0, 0, 0);
        check_val("t2_day_off", int'(day_pulse), 0);

        // 3: hours edit wraps at 23, ticks frozen
        drive(0, 1, 0);
        repeat (25) drive(0, 0, 1);
        check_val("t3_mode", int'(set_mode), 1);
        check_val("t3_hh", int'(hh), 1);
        check_val("t3_mm", int'(mm), 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        check_val("t3_ss_frozen", int'(ss), 0);

        // 4: blanking in SET_MM lags blink by one cycle; none in RUN
        drive(0, 1, 0);
        blink_2hz = 1;
        #1 check_val("t4_lag", int'(blank_mm), 0);
        drive(0, 0, 0);
        check_val("t4_bm", int'(blank_mm), 1);
        check_val("t4_bh", int'(blank_hh), 0);
        check_val("t4_bs", int'(blank_ss), 0);
        blink_2hz = 0;
        drive(0, 0, 0);
        check_val("t4_bm_off", int'(blank_mm), 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        blink_2hz = 1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        check_val("t4_run_bs", int'(blank_ss) + int'(blank_mm) + int'(blank_hh), 0);
        blink_2hz = 0;

        // 5: mode beats inc, then async reset mid-edit
        drive(0, 1, 0);
        repeat (4) drive(0, 0, 1);
        check_val("t5_hh5", int'(hh), 5);
        drive(0, 1, 1);
        check_val("t5_mode", int'(set_mode), 2);
        check_val("t5_hh_kept", int'(hh), 5);
        do_reset();
        check_val("t5_rst_mode", int'(set_mode), 0);
        check_val("t5_rst_hh", int'(hh), 0);

`ifdef CLOCK_SET_TIMEOUT_EN
        // 6: idle timeout returns to RUN keeping the edit
        drive(0, 1, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        check_val("t6_still_set", int'(set_mode), 1);
        drive(1, 0, 0);
        check_val("t6_timeout", int'(set_mode), 0);
        check_val("t6_hh", int'(hh), 1);
`endif

        // random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7, 0) == 0) blink_2hz = ~blink_2hz;
            if ($urandom_range(399, 0) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(3, 0) == 0,
                      $urandom_range(19, 0) == 0,
                      $urandom_range(3, 0) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
